// File: rtl/microcode_sequencer_if.sv
// ---------------------------------------------------------------------------
// microcode_sequencer_if
// Issue channel between the microcode sequencer and the execution datapath.
// The sequencer (master) presents an EXEC uop with uop_valid and holds it
// until the datapath (slave) raises uop_ready on the same cycle.
//   uop_valid  master->slave  uop_data holds an EXEC-class uop
//   uop_ready  slave->master  datapath accepts the uop this cycle
//   uop_data   master->slave  the issued uop word
// ---------------------------------------------------------------------------
interface microcode_sequencer_if #(
   parameter int UOP_W = 32
);
   logic             uop_valid;
   logic             uop_ready;
   logic [UOP_W-1:0] uop_data;

   modport master (
      output uop_valid,
      output uop_data,
      input  uop_ready
   );

   modport slave (
      input  uop_valid,
      input  uop_data,
      output uop_ready
   );
endinterface

// File: rtl/microcode_sequencer.sv
// ---------------------------------------------------------------------------
// microcode_sequencer
// Microcode engine with a writable uop store. It walks the store from a
// start address, handles jumps, conditional jumps, call/return through a
// small return-address stack and wait-on-condition, and issues EXEC-class
// uops to the datapath over a valid/ready channel.
// Ports:
//   clk         clock, everything on the rising edge
//   reset       synchronous, active-low reset
//   start       begin sequencing at start_addr (ignored while running)
//   start_addr  entry point
//   wr_en       uop store write strobe, legal in every state
//   wr_addr     store write address
//   wr_data     store write data
//   cond_i      external condition flags selected by the uop cond field
//   uopBus      issue channel (uop_valid, uop_ready, uop_data)
//   pc          address of the uop being decoded
//   busy        running
//   halted      stopped by a HALT uop
//   error       stopped by a bad target or stack over/underflow
// ---------------------------------------------------------------------------
module microcode_sequencer #(
   parameter int UOP_W       = 32,
   parameter int DEPTH       = 128,
   parameter int ADDR_W      = $clog2(DEPTH),
   parameter int STACK_DEPTH = 4,
   parameter int NUM_COND    = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [ADDR_W-1:0]    start_addr,
   input  logic                 wr_en,
   input  logic [ADDR_W-1:0]    wr_addr,
   input  logic [UOP_W-1:0]     wr_data,
   input  logic [NUM_COND-1:0]  cond_i,
   microcode_sequencer_if.master uopBus,
   output logic [ADDR_W-1:0]    pc,
   output logic                 busy,
   output logic                 halted,
   output logic                 error
);

   localparam int SP_W     = $clog2(STACK_DEPTH + 1);
   localparam int SP_IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   localparam logic [3:0] OP_EXEC = 4'd0;
   localparam logic [3:0] OP_JMP  = 4'd1;
   localparam logic [3:0] OP_JCC  = 4'd2;
   localparam logic [3:0] OP_CALL = 4'd3;
   localparam logic [3:0] OP_RET  = 4'd4;
   localparam logic [3:0] OP_HALT = 4'd5;
   localparam logic [3:0] OP_WAIT = 4'd6;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      HALT,
      ERR
   } seqState_e;

   seqState_e         state;
   seqState_e         stateNext;
   logic [ADDR_W-1:0] pcReg;
   logic [ADDR_W-1:0] pcNext;
   logic [ADDR_W-1:0] pcInc;
   logic [SP_W-1:0]   sp;
   logic [SP_W-1:0]   spNext;
   logic [SP_W-1:0]   spDec;
   logic              pushEn;
   logic              issueValid;

   logic [UOP_W-1:0]  mem [DEPTH];
   logic [ADDR_W-1:0] stack [STACK_DEPTH];

   logic [UOP_W-1:0]  uop;
   logic [3:0]        opcode;
   logic [3:0]        condSel;
   logic [ADDR_W-1:0] target;
   logic              targetOk;
   logic              condBit;
   logic              spAtTop;
   logic [ADDR_W-1:0] stackTop;

   // Field extraction and helper values for the uop under the pc. The store
   // is read asynchronously, so a write to the current pc is seen the cycle
   // after the write edge. A condition select beyond the implemented inputs
   // reads as 0. The pc increment compares against DEPTH-1 explicitly so the
   // wrap is correct even when DEPTH is not a power of two.
   always_comb begin
      uop      = mem[pcReg];
      opcode   = uop[UOP_W-1 -: 4];
      condSel  = uop[UOP_W-5 -: 4];
      target   = uop[ADDR_W-1:0];
      targetOk = (int'(target) < DEPTH);
      condBit  = 1'b0;
      for (int i = 0; i < NUM_COND; i++) begin
         if (int'(condSel) == i) begin
            condBit = cond_i[i];
         end
      end
      pcInc    = (int'(pcReg) == DEPTH - 1) ? '0 : pcReg + 1'b1;
      spAtTop  = (int'(sp) == STACK_DEPTH);
      spDec    = sp - 1'b1;
      stackTop = stack[spDec[SP_IDX_W-1:0]];
   end

   // Next-state decode. Outside RUN only start matters. In RUN exactly one
   // uop is decoded per cycle; control uops take one cycle and never issue.
   // Opcodes 7-15 fall into the default branch and behave as EXEC. Faults
   // leave pc on the faulting uop so software can see where it stopped.
   always_comb begin
      stateNext  = state;
      pcNext     = pcReg;
      spNext     = sp;
      pushEn     = 1'b0;
      issueValid = 1'b0;
      case (state)
         IDLE, HALT, ERR: begin
            if (start) begin
               stateNext = RUN;
               pcNext    = start_addr;
               spNext    = '0;
            end
         end
         RUN: begin
            case (opcode)
               OP_JMP: begin
                  if (targetOk) begin
                     pcNext = target;
                  end else begin
                     stateNext = ERR;
                  end
               end
               OP_JCC: begin
                  if (!condBit) begin
                     pcNext = pcInc;
                  end else if (targetOk) begin
                     pcNext = target;
                  end else begin
                     stateNext = ERR;
                  end
               end
               OP_CALL: begin
                  if (spAtTop || !targetOk) begin
                     stateNext = ERR;
                  end else begin
                     pushEn = 1'b1;
                     spNext = sp + 1'b1;
                     pcNext = target;
                  end
               end
               OP_RET: begin
                  if (sp == '0) begin
                     stateNext = ERR;
                  end else begin
                     pcNext = stackTop;
                     spNext = spDec;
                  end
               end
               OP_HALT: begin
                  stateNext = HALT;
               end
               OP_WAIT: begin
                  if (condBit) begin
                     pcNext = pcInc;
                  end
               end
               default: begin
                  issueValid = 1'b1;
                  if (uopBus.uop_ready) begin
                     pcNext = pcInc;
                  end
               end
            endcase
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // State, pc and stack pointer. Reset returns to IDLE with an empty stack,
   // which also drops any uop that was being offered downstream.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         pcReg <= '0;
         sp    <= '0;
      end else begin
         state <= stateNext;
         pcReg <= pcNext;
         sp    <= spNext;
      end
   end

   // Return-address stack storage. Only the pointer is reset; entries above
   // the pointer are never read, so their contents do not matter.
   always_ff @(posedge clk) begin
      if (reset && pushEn) begin
         stack[sp[SP_IDX_W-1:0]] <= pcInc;
      end
   end

   // uop store write port. Contents survive reset so a loaded program can be
   // restarted without reloading. Out-of-range addresses are dropped.
   always_ff @(posedge clk) begin
      if (wr_en && (int'(wr_addr) < DEPTH)) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Output drive. uop_data is forced to zero whenever nothing is offered so
   // the datapath never sees stale store contents.
   assign uopBus.uop_valid = issueValid;
   assign uopBus.uop_data  = issueValid ? uop : '0;
   assign pc               = pcReg;
   assign busy             = (state == RUN);
   assign halted           = (state == HALT);
   assign error            = (state == ERR);

endmodule

// File: tb/tb_microcode_sequencer.sv
// ---------------------------------------------------------------------------
// tb_microcode_sequencer
// Self-checking bench for microcode_sequencer. Expected EXEC beats are queued
// when a program is started and popped by a monitor whenever the sequencer
// hands a uop over; control-flow results (pc, flags, cycle counts) are
// checked directly against hand-derived values.
// ---------------------------------------------------------------------------
module tb_microcode_sequencer;

   logic        clk;
   logic        reset;
   logic        start;
   logic [6:0]  start_addr;
   logic        wr_en;
   logic [6:0]  wr_addr;
   logic [31:0] wr_data;
   logic [3:0]  cond_i;
   logic [6:0]  pc;
   logic        busy;
   logic        halted;
   logic        error;

   int          vectorCount;
   int          missCount;
   int          beatCount;
   logic [31:0] expQ [$];

   microcode_sequencer_if #(.UOP_W(32)) bus ();

   microcode_sequencer #(
      .UOP_W(32),
      .DEPTH(128),
      .STACK_DEPTH(4),
      .NUM_COND(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .start_addr(start_addr),
      .wr_en(wr_en),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .cond_i(cond_i),
      .uopBus(bus),
      .pc(pc),
      .busy(busy),
      .halted(halted),
      .error(error)
   );

   // 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case a bounded wait is somehow bypassed.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, want finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts every check and reports miscompares.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
      end
   endtask

   // Scoreboard monitor: every accepted beat must match the oldest queued one.
   always @(negedge clk) begin
      if (reset && bus.uop_valid && bus.uop_ready) begin
         beatCount++;
         if (expQ.size() == 0) begin
            checkOutput("unexpectedBeat", bus.uop_data, 32'h0);
         end else begin
            checkOutput("beatData", bus.uop_data, expQ.pop_front());
         end
      end
   end

   function automatic logic [31:0] mkCtl(input logic [3:0] op, input logic [3:0] sel,
                                         input logic [6:0] tgt);
      return {op, sel, 17'd0, tgt};
   endfunction

   function automatic logic [31:0] mkExec(input logic [23:0] payload);
      return {4'h0, 4'h0, payload};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic writeUop(input logic [6:0] addr, input logic [31:0] data);
      wr_en   = 1'b1;
      wr_addr = addr;
      wr_data = data;
      tick();
      wr_en   = 1'b0;
   endtask

   // Pulse start for one edge; on return the first decode cycle is visible.
   task automatic applyStimulus(input logic [6:0] addr);
      start      = 1'b1;
      start_addr = addr;
      tick();
      start      = 1'b0;
   endtask

   // Wait (bounded) for halted or error; an expired bound shows up as a miss.
   task automatic waitFlag(input string tag, input bit wantErr, input int bound,
                           output int ticks);
      ticks = 0;
      while (!(wantErr ? error : halted) && ticks < bound) begin
         tick();
         ticks++;
      end
      checkOutput(tag, 32'(wantErr ? error : halted), 32'd1);
   endtask

   initial begin
      int          t;
      int          beatsBefore;
      logic [31:0] held;

      vectorCount   = 0;
      missCount     = 0;
      beatCount     = 0;
      reset         = 1'b0;
      start         = 1'b0;
      start_addr    = '0;
      wr_en         = 1'b0;
      wr_addr       = '0;
      wr_data       = '0;
      cond_i        = '0;
      bus.uop_ready = 1'b0;

      tick();
      tick();
      checkOutput("rstBusy", 32'(busy), 32'd0);
      checkOutput("rstHalted", 32'(halted), 32'd0);
      checkOutput("rstError", 32'(error), 32'd0);
      checkOutput("rstPc", 32'(pc), 32'd0);
      checkOutput("rstValid", 32'(bus.uop_valid), 32'd0);
      checkOutput("rstData", bus.uop_data, 32'd0);
      reset = 1'b1;

      writeUop(7'd0, mkExec(24'h0000A0));
      writeUop(7'd1, mkExec(24'h0000A1));
      writeUop(7'd2, {4'hF, 28'h00000A2});
      writeUop(7'd3, mkCtl(4'd5, 4'd0, 7'd0));

      beatsBefore = beatCount;
      expQ.push_back(mkExec(24'h0000A0));
      expQ.push_back(mkExec(24'h0000A1));
      expQ.push_back({4'hF, 28'h00000A2});
      bus.uop_ready = 1'b1;
      applyStimulus(7'd0);
      checkOutput("firstBusy", 32'(busy), 32'd1);
      checkOutput("firstValid", 32'(bus.uop_valid), 32'd1);
      checkOutput("firstPc", 32'(pc), 32'd0);
      waitFlag("p1Halt", 1'b0, 20, t);
      checkOutput("p1HaltCycles", 32'(t), 32'd4);
      checkOutput("p1Pc", 32'(pc), 32'd3);
      checkOutput("p1Beats", 32'(beatCount - beatsBefore), 32'd3);

      beatsBefore = beatCount;
      expQ.push_back(mkExec(24'h0000A0));
      expQ.push_back(mkExec(24'h0000A1));
      expQ.push_back({4'hF, 28'h00000A2});
      applyStimulus(7'd0);
      tick();
      bus.uop_ready = 1'b0;
      held = bus.uop_data;
      checkOutput("stallFirst", held, mkExec(24'h0000A1));
      for (int i = 0; i < 2; i++) begin
         tick();
         checkOutput("stallPc", 32'(pc), 32'd1);
         checkOutput("stallValid", 32'(bus.uop_valid), 32'd1);
         checkOutput("stallData", bus.uop_data, mkExec(24'h0000A1));
      end
      bus.uop_ready = 1'b1;
      waitFlag("p2Halt", 1'b0, 20, t);
      checkOutput("p2Pc", 32'(pc), 32'd3);
      checkOutput("p2Beats", 32'(beatCount - beatsBefore), 32'd3);

      writeUop(7'd0, mkCtl(4'd2, 4'd2, 7'd5));
      writeUop(7'd1, mkCtl(4'd5, 4'd0, 7'd0));
      writeUop(7'd5, mkCtl(4'd5, 4'd0, 7'd0));
      cond_i = 4'b0100;
      applyStimulus(7'd0);
      checkOutput("jccValid", 32'(bus.uop_valid), 32'd0);
      tick();
      checkOutput("jccTaken", 32'(pc), 32'd5);
      waitFlag("jccHaltA", 1'b0, 5, t);
      cond_i = 4'b0000;
      applyStimulus(7'd0);
      tick();
      checkOutput("jccNotTaken", 32'(pc), 32'd1);
      waitFlag("jccHaltB", 1'b0, 5, t);

      writeUop(7'd52, mkCtl(4'd2, 4'd9, 7'd55));
      writeUop(7'd53, mkCtl(4'd5, 4'd0, 7'd0));
      writeUop(7'd55, mkCtl(4'd5, 4'd0, 7'd0));
      cond_i = 4'b1111;
      applyStimulus(7'd52);
      tick();
      checkOutput("selOutOfRange", 32'(pc), 32'd53);
      waitFlag("selHalt", 1'b0, 5, t);

      for (int i = 0; i < 5; i++) begin
         writeUop(7'(10 + i), mkCtl(4'd3, 4'd0, 7'(11 + i)));
      end
      applyStimulus(7'd10);
      waitFlag("callOverflow", 1'b1, 20, t);
      checkOutput("callOvfCycles", 32'(t), 32'd5);
      checkOutput("callOvfPc", 32'(pc), 32'd14);
      checkOutput("callOvfBusy", 32'(busy), 32'd0);
      checkOutput("callOvfValid", 32'(bus.uop_valid), 32'd0);

      writeUop(7'd20, mkCtl(4'd4, 4'd0, 7'd0));
      applyStimulus(7'd20);
      tick();
      checkOutput("retUnderflow", 32'(error), 32'd1);
      checkOutput("retUnderPc", 32'(pc), 32'd20);

      writeUop(7'd30, mkCtl(4'd3, 4'd0, 7'd40));
      writeUop(7'd31, mkCtl(4'd5, 4'd0, 7'd0));
      writeUop(7'd40, mkCtl(4'd4, 4'd0, 7'd0));
      applyStimulus(7'd30);
      checkOutput("errExitBusy", 32'(busy), 32'd1);
      tick();
      checkOutput("callTarget", 32'(pc), 32'd40);
      tick();
      checkOutput("retAddr", 32'(pc), 32'd31);
      waitFlag("callRetHalt", 1'b0, 5, t);
      checkOutput("callRetErr", 32'(error), 32'd0);

      writeUop(7'd60, mkCtl(4'd1, 4'd0, 7'd62));
      writeUop(7'd61, mkCtl(4'd4, 4'd0, 7'd0));
      writeUop(7'd62, mkCtl(4'd5, 4'd0, 7'd0));
      applyStimulus(7'd60);
      waitFlag("jmpHalt", 1'b0, 5, t);
      checkOutput("jmpPc", 32'(pc), 32'd62);

      writeUop(7'd127, mkExec(24'h007F7F));
      writeUop(7'd0, mkCtl(4'd5, 4'd0, 7'd0));
      expQ.push_back(mkExec(24'h007F7F));
      applyStimulus(7'd127);
      waitFlag("wrapHalt", 1'b0, 5, t);
      checkOutput("wrapPc", 32'(pc), 32'd0);

      writeUop(7'd50, mkCtl(4'd6, 4'd1, 7'd0));
      writeUop(7'd51, mkCtl(4'd5, 4'd0, 7'd0));
      cond_i = 4'b1101;
      applyStimulus(7'd50);
      tick();
      tick();
      tick();
      checkOutput("waitPc", 32'(pc), 32'd50);
      checkOutput("waitBusy", 32'(busy), 32'd1);
      checkOutput("waitValid", 32'(bus.uop_valid), 32'd0);
      cond_i = 4'b0010;
      tick();
      checkOutput("waitRelease", 32'(pc), 32'd51);
      waitFlag("waitHalt", 1'b0, 5, t);

      writeUop(7'd70, mkExec(24'h700070));
      writeUop(7'd71, mkCtl(4'd5, 4'd0, 7'd0));
      bus.uop_ready = 1'b0;
      applyStimulus(7'd70);
      tick();
      checkOutput("preRstValid", 32'(bus.uop_valid), 32'd1);
      checkOutput("preRstPc", 32'(pc), 32'd70);
      reset = 1'b0;
      tick();
      checkOutput("midRstBusy", 32'(busy), 32'd0);
      checkOutput("midRstValid", 32'(bus.uop_valid), 32'd0);
      checkOutput("midRstPc", 32'(pc), 32'd0);
      checkOutput("midRstData", bus.uop_data, 32'd0);
      reset = 1'b1;
      bus.uop_ready = 1'b1;
      expQ.push_back(mkExec(24'h700070));
      applyStimulus(7'd70);
      waitFlag("storeIntactHalt", 1'b0, 5, t);
      checkOutput("storeIntactPc", 32'(pc), 32'd71);

      tick();
      checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
